// File: rtl/sampler_pkg.sv
// Shared sync parameters: data width, register map and sampler FSM encodings.
package sampler_pkg;
  localparam int MSB    = 15;
  localparam int DATA_W = MSB + 1;

  localparam logic [3:0] NUMSAMPLESREG_ADDR = 4'h4;
  localparam logic [3:0] SUBVALUEREG_ADDR   = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/sampler_sat_sub.sv
// Unsigned subtract clamped at zero.
module sat_sub #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = (a < b) ? '0 : (a - b);
endmodule

// File: rtl/sampler_top.sv
// Offset-corrected sample capture: single holding register feeding a valid/ready
// stream, with overrun detection and a fixed per-measurement sample count.
module sampler_top #(
  parameter int DATA_W = sampler_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_numsamples,
  input  logic [DATA_W-1:0] cfg_subvalue,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);
  import sampler_pkg::*;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] num_q, num_d;
  logic [DATA_W-1:0] sub_q, sub_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic [DATA_W-1:0] sub_res;
  logic [DATA_W-1:0] cnt_inc;
  logic              hs;

  sat_sub #(.W(DATA_W)) u_sat_sub (
    .a (adc_data),
    .b (sub_q),
    .y (sub_res)
  );

  assign cnt_inc = cnt_q + {{(DATA_W-1){1'b0}}, 1'b1};
  assign hs      = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d = cfg_numsamples;
          sub_d = cfg_subvalue;
          cnt_d = '0;
          // Empty measurement completes immediately without entering RUN.
          if (cfg_numsamples == '0) done_d  = 1'b1;
          else                      state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (adc_valid) begin
          // A full holding register can still take a sample if it drains this cycle.
          if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = sub_res;
            cnt_d       = cnt_inc;
            out_last_d  = (cnt_inc == num_q);
            if (cnt_inc == num_q) state_d = ST_DRAIN;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      sub_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sampler_top.sv
// Directed bench for sampler_top: hand-computed vectors checked 1ns after each clk edge.
module tb_sampler_top;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_numsamples = '0;
  logic [DW-1:0] cfg_subvalue = '0;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          overrun;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] norm_in  [4] = '{16'd150, 16'd90, 16'd300, 16'd100};
  logic [DW-1:0] norm_exp [4] = '{16'd50,  16'd0,  16'd200, 16'd0};

  always #5 clk = ~clk;

  sampler_top #(.DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_numsamples (cfg_numsamples),
    .cfg_subvalue   (cfg_subvalue),
    .adc_valid      (adc_valid),
    .adc_data       (adc_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [DW-1:0] num, input logic [DW-1:0] sub);
    cfg_numsamples = num;
    cfg_subvalue   = sub;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int lasts;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_last",  out_last,  0);
    chk("rst_busy",  busy,      0);
    chk("rst_done",  done,      0);
    chk("rst_ovr",   overrun,   0);
    tick();
    rst_n = 1'b1;
    tick();

    // Normal run, streaming with out_ready held high.
    out_ready = 1'b1;
    do_start(16'd4, 16'd100);
    chk("norm_busy",   busy,      1);
    chk("norm_valid0", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      adc_data  = norm_in[i];
      tick();
      chk("norm_valid", out_valid, 1);
      chk("norm_data",  out_data,  norm_exp[i]);
      chk("norm_last",  out_last,  (i == 3) ? 1 : 0);
      chk("norm_ovr",   overrun,   0);
    end
    adc_valid = 1'b0;
    tick();
    chk("norm_done",   done,      1);
    chk("norm_busy_e", busy,      0);
    chk("norm_valid_e", out_valid, 0);
    tick();
    chk("norm_done_pulse", done, 0);

    // Back-pressure with overruns, then simultaneous drain+accept.
    out_ready = 1'b0;
    do_start(16'd3, 16'd10);
    adc_valid = 1'b1; adc_data = 16'd50;
    tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_data0", out_data,  40);
    chk("bp_ovr0",  overrun,   0);
    adc_data = 16'd70;
    tick();
    chk("bp_ovr1",  overrun,  1);
    chk("bp_data1", out_data, 40);
    adc_valid = 1'b0;
    tick();
    chk("bp_ovr_gap", overrun,  0);
    chk("bp_data2",   out_data, 40);
    adc_valid = 1'b1; adc_data = 16'd80;
    tick();
    chk("bp_ovr2",  overrun,  1);
    chk("bp_data3", out_data, 40);
    chk("bp_last3", out_last, 0);
    out_ready = 1'b1; adc_data = 16'd25;
    tick();
    chk("sim_data",  out_data,  15);
    chk("sim_valid", out_valid, 1);
    chk("sim_ovr",   overrun,   0);
    chk("sim_last",  out_last,  0);
    adc_data = 16'd5;
    tick();
    chk("sim_sat",   out_data, 0);
    chk("sim_last2", out_last, 1);
    out_ready = 1'b0; adc_data = 16'd99;
    tick();
    chk("drain_ovr",  overrun,  0);
    chk("drain_data", out_data, 0);
    chk("drain_busy", busy,     1);
    adc_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_done", done, 1);
    chk("bp_busy", busy, 0);

    // Zero sample count.
    do_start(16'd0, 16'd0);
    chk("zero_done",  done,      1);
    chk("zero_valid", out_valid, 0);
    chk("zero_busy",  busy,      0);
    tick();
    chk("zero_done2",  done,      0);
    chk("zero_valid2", out_valid, 0);

    // Config change and start while busy must not disturb the run.
    do_start(16'd2, 16'd100);
    cfg_subvalue = 16'd0; cfg_numsamples = 16'd9; start = 1'b1;
    adc_valid = 1'b1; adc_data = 16'd300;
    tick();
    start = 1'b0;
    chk("cfg_data0", out_data, 200);
    chk("cfg_last0", out_last, 0);
    adc_data = 16'd150;
    tick();
    chk("cfg_data1", out_data, 50);
    chk("cfg_last1", out_last, 1);
    adc_valid = 1'b0;
    tick();
    chk("cfg_done", done, 1);
    chk("cfg_busy", busy, 0);

    // Reset mid-run while a sample is held.
    out_ready = 1'b0;
    do_start(16'd5, 16'd0);
    adc_valid = 1'b1; adc_data = 16'd7;
    tick();
    adc_valid = 1'b0;
    chk("mr_valid_pre", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_data",  out_data,  0);
    chk("mr_busy",  busy,      0);
    chk("mr_last",  out_last,  0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1; adc_valid = 1'b1; adc_data = 16'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_idle_valid", out_valid, 0);
      chk("mr_idle_done",  done,      0);
      chk("mr_idle_busy",  busy,      0);
    end
    adc_valid = 1'b0;

    // Full-scale count runs to completion without wrapping.
    do_start(16'hFFFF, 16'd0);
    lasts = 0;
    for (int i = 0; i < 65535; i++) begin
      adc_valid = 1'b1;
      adc_data  = DW'(i);
      tick();
      if (out_last) lasts++;
    end
    chk("max_last",  out_last, 1);
    chk("max_data",  out_data, 16'hFFFE);
    chk("max_lasts", lasts,    1);
    adc_valid = 1'b0;
    tick();
    chk("max_done", done, 1);
    chk("max_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
